// File: rtl/coax_tx.sv
// -----------------------------------------------------------------------------
// coax_tx - 3270 coax link transmitter
//
// A one-word holding register accepts 10-bit words from the shared data bus.
// Each message is framed as: line quiesce (five '1' bits), a code violation,
// then for every queued word a sync '1', ten data bits (MSB first) and an even
// parity bit. The message ends with an end sequence ('0' bit, then a full bit
// time high). Bits are biphase coded: '1' = low then high, '0' = high then low.
//
// Parameters
//   CLOCKS_PER_BIT : clk cycles per bit time (even, >= 4)
//
// Ports
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   data   : word to transmit, sampled when strobe && ready
//   strobe : one-cycle load request
//   ready  : holding register empty, a word can be loaded
//   active : high for the whole message, enables the external line driver
//   tx     : serial line output
// -----------------------------------------------------------------------------
module coax_tx #(
   parameter int CLOCKS_PER_BIT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] data,
   input  logic       strobe,
   output logic       ready,
   output logic       active,
   output logic       tx
);

   localparam int              CW     = $clog2(CLOCKS_PER_BIT);
   localparam logic [CW-1:0]   C_LAST = CW'(CLOCKS_PER_BIT - 1);
   localparam logic [CW-1:0]   C_HALF = CW'(CLOCKS_PER_BIT / 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_QUIESCE,
      S_VIOLATION,
      S_SYNC,
      S_DATA,
      S_PARITY,
      S_END
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_clk_cnt;
   logic [3:0]      r_bit_cnt;
   logic [9:0]      r_hold;
   logic [9:0]      r_shift;
   logic            r_full;

   logic            w_load;
   logic            w_xfer;
   logic            w_bit_end;
   logic            w_state_end;
   logic            w_first_half;
   logic            w_bit_val;
   logic [3:0]      w_last_bit;
   logic [2:0]      w_half_idx;

   assign w_load       = strobe && !r_full;
   assign w_bit_end    = (r_clk_cnt == C_LAST);
   assign w_first_half = (r_clk_cnt < C_HALF);
   // Holding register moves to the shift register on the first SYNC clock.
   assign w_xfer       = (r_state == S_SYNC) && (r_clk_cnt == '0) && (r_bit_cnt == 4'd0);
   // Half-bit index inside the three-bit-time code violation.
   assign w_half_idx   = {r_bit_cnt[1:0], ~w_first_half};

   // Index of the last bit time of each framing state.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can
      // leave it unassigned and infer a latch.
      w_last_bit = 4'd0;
      case (r_state)
         S_QUIESCE:   w_last_bit = 4'd4;
         S_VIOLATION: w_last_bit = 4'd2;
         S_DATA:      w_last_bit = 4'd9;
         S_END:       w_last_bit = 4'd1;
         default:     w_last_bit = 4'd0;
      endcase
   end

   assign w_state_end = w_bit_end && (r_bit_cnt == w_last_bit);

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (w_load || r_full) w_next = S_QUIESCE;
         S_QUIESCE:   if (w_state_end) w_next = S_VIOLATION;
         S_VIOLATION: if (w_state_end) w_next = S_SYNC;
         S_SYNC:      if (w_state_end) w_next = S_DATA;
         S_DATA:      if (w_state_end) w_next = S_PARITY;
         // A word queued before the parity bit ends follows with no gap.
         S_PARITY:    if (w_state_end) w_next = r_full ? S_SYNC : S_END;
         S_END:       if (w_state_end) w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   // Outputs decode only registered state, so strobe/data never reach tx
   // combinationally.
   always_comb begin
      w_bit_val = 1'b1;
      tx        = 1'b0;
      case (r_state)
         S_QUIESCE,
         S_SYNC:      w_bit_val = 1'b1;
         S_DATA:      w_bit_val = r_shift[4'd9 - r_bit_cnt];
         S_PARITY:    w_bit_val = ^r_shift;
         S_END:       w_bit_val = 1'b0;
         default:     w_bit_val = 1'b1;
      endcase
      case (r_state)
         S_IDLE:      tx = 1'b0;
         S_VIOLATION: tx = (w_half_idx < 3'd3);
         // Second END bit time is held high rather than biphase coded.
         S_END:       tx = (r_bit_cnt == 4'd0) ? (w_bit_val ^ w_first_half) : 1'b1;
         default:     tx = w_bit_val ^ w_first_half;
      endcase
   end

   assign active = (r_state != S_IDLE);
   assign ready  = !r_full;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         r_state   <= S_IDLE;
         r_clk_cnt <= '0;
         r_bit_cnt <= 4'd0;
         r_hold    <= 10'd0;
         r_shift   <= 10'd0;
         r_full    <= 1'b0;
      end else begin
         r_state <= w_next;

         if (r_state == S_IDLE) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= 4'd0;
         end else if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= w_state_end ? 4'd0 : r_bit_cnt + 4'd1;
         end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
         end

         if (w_xfer) begin
            r_shift <= r_hold;
         end

         // A load and a transfer cannot coincide: the transfer happens only
         // while the holding register is full, when loads are refused.
         if (w_load) begin
            r_hold <= data;
            r_full <= 1'b1;
         end else if (w_xfer) begin
            r_full <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_coax_tx.sv
// -----------------------------------------------------------------------------
// tb_coax_tx - directed testbench for coax_tx
//
// Two instances: CLOCKS_PER_BIT=8 (main) and CLOCKS_PER_BIT=4. The tx stream
// is captured for the whole time active is high and compared with a waveform
// built from the expected bit sequence, plus hand-computed decoded fields.
// -----------------------------------------------------------------------------
module tb_coax_tx;

   logic       clk;
   logic       reset;
   logic [9:0] data;
   logic       strobe8, strobe4;
   logic       ready8, active8, tx8;
   logic       ready4, active4, tx4;

   coax_tx #(.CLOCKS_PER_BIT(8)) dut8 (
      .clk(clk), .reset(reset), .data(data), .strobe(strobe8),
      .ready(ready8), .active(active8), .tx(tx8)
   );

   coax_tx #(.CLOCKS_PER_BIT(4)) dut4 (
      .clk(clk), .reset(reset), .data(data), .strobe(strobe4),
      .ready(ready4), .active(active4), .tx(tx4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   logic       cap [4096];
   int         cap_len;
   logic       exp_w [4096];
   int         exp_len;
   logic [9:0] exp_words [$];
   logic [9:0] pending [$];
   int         first_ready;
   int         strobe_at = -1;
   logic [9:0] strobe_word = 10'd0;
   int         reset_at = -1;

   task automatic check(input string tag, input int obs, input int expv);
      n_cmp++;
      if (obs !== expv) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_strobe(input int which, input logic v);
      if (which == 1) strobe4 = v;
      else            strobe8 = v;
   endtask

   // Expected waveform model.
   task automatic emit_bit(input int cpb, input logic b);
      for (int c = 0; c < cpb; c++) begin
         exp_w[exp_len] = (c < cpb / 2) ? ~b : b;
         exp_len++;
      end
   endtask

   task automatic build_exp(input int cpb);
      logic [9:0] w;
      exp_len = 0;
      for (int i = 0; i < 5; i++) emit_bit(cpb, 1'b1);
      for (int c = 0; c < 3 * cpb; c++) begin
         exp_w[exp_len] = (c < 3 * (cpb / 2));
         exp_len++;
      end
      for (int k = 0; k < exp_words.size(); k++) begin
         w = exp_words[k];
         emit_bit(cpb, 1'b1);
         for (int i = 9; i >= 0; i--) emit_bit(cpb, w[i]);
         emit_bit(cpb, ^w);
      end
      emit_bit(cpb, 1'b0);
      for (int c = 0; c < cpb; c++) begin
         exp_w[exp_len] = 1'b1;
         exp_len++;
      end
   endtask

   // Record tx every cycle while active, starting on the current cycle.
   task automatic capture(input int which, input int refill);
      int   n;
      logic act, rdy;
      n = 0;
      first_ready = -1;
      act = (which == 1) ? active4 : active8;
      while (act && n < 4000) begin
         rdy    = (which == 1) ? ready4 : ready8;
         cap[n] = (which == 1) ? tx4 : tx8;
         if (first_ready < 0 && rdy) first_ready = n;
         if (n == reset_at) reset = 1'b1;
         if (n == strobe_at) begin
            data = strobe_word;
            set_strobe(which, 1'b1);
         end else if (refill != 0 && rdy && pending.size() > 0) begin
            data = pending.pop_front();
            set_strobe(which, 1'b1);
         end else begin
            set_strobe(which, 1'b0);
         end
         n++;
         tick();
         act = (which == 1) ? active4 : active8;
      end
      set_strobe(which, 1'b0);
      cap_len = n;
   endtask

   task automatic check_frame(input string tag, input int expected_len);
      int mism, lim;
      mism = 0;
      lim  = (cap_len < exp_len) ? cap_len : exp_len;
      for (int i = 0; i < lim; i++)
         if (cap[i] !== exp_w[i]) mism++;
      check({tag, "_len"}, cap_len, expected_len);
      check({tag, "_wave"}, mism, 0);
   endtask

   // Bit value of bit time bt is the second-half level.
   function automatic int dbit(input int bt, input int cpb);
      return int'(cap[bt * cpb + cpb / 2]);
   endfunction

   function automatic int dword(input int j, input int cpb);
      int w;
      w = 0;
      for (int i = 0; i < 10; i++) w = (w << 1) | dbit(9 + 12 * j + i, cpb);
      return w;
   endfunction

   task automatic start_word(input int which, input logic [9:0] w);
      data = w;
      set_strobe(which, 1'b1);
      tick();
      set_strobe(which, 1'b0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; data = 10'd0; strobe8 = 1'b0; strobe4 = 1'b0;
      repeat (3) tick();
      check("rst_tx", int'(tx8), 0);
      check("rst_active", int'(active8), 0);
      check("rst_ready", int'(ready8), 1);
      reset = 1'b0;
      repeat (2) tick();

      // 1: single word
      exp_words = {10'h2AA}; build_exp(8);
      start_word(0, 10'h2AA);
      capture(0, 0);
      check_frame("t1", 176);
      check("t1_ready_low", first_ready, 65);
      check("t1_word", dword(0, 8), 'h2AA);
      check("t1_parity", dbit(19, 8), 1);
      check("t1_idle_tx", int'(tx8), 0);
      repeat (3) tick();

      // 2: three back-to-back words
      exp_words = {10'h001, 10'h3FF, 10'h000}; build_exp(8);
      start_word(0, 10'h001);
      pending = {10'h3FF, 10'h000};
      capture(0, 1);
      check_frame("t2", 368);
      check("t2_par0", dbit(19, 8), 1);
      check("t2_par1", dbit(31, 8), 0);
      check("t2_par2", dbit(43, 8), 0);
      check("t2_word1", dword(1, 8), 'h3FF);
      repeat (3) tick();

      // 3: strobe while not ready is dropped
      exp_words = {10'h2AA}; build_exp(8);
      strobe_at = 10; strobe_word = 10'h155;
      start_word(0, 10'h2AA);
      capture(0, 0);
      strobe_at = -1;
      check_frame("t3", 176);
      check("t3_word", dword(0, 8), 'h2AA);
      repeat (3) tick();

      // 4: reset during 5th data bit, then a clean frame
      reset_at = 106;
      start_word(0, 10'h2AA);
      capture(0, 0);
      reset_at = -1;
      check("t4_abort_len", cap_len, 107);
      check("t4_rst_tx", int'(tx8), 0);
      check("t4_rst_active", int'(active8), 0);
      check("t4_rst_ready", int'(ready8), 1);
      reset = 1'b0;
      tick();
      start_word(0, 10'h2AA);
      capture(0, 0);
      check_frame("t4", 176);

      // 5: strobe during END high period
      repeat (3) tick();
      strobe_at = 170; strobe_word = 10'h0F0;
      start_word(0, 10'h2AA);
      capture(0, 0);
      strobe_at = -1;
      check_frame("t5a", 176);
      check("t5_gap_active", int'(active8), 0);
      check("t5_gap_tx", int'(tx8), 0);
      tick();
      exp_words = {10'h0F0}; build_exp(8);
      capture(0, 0);
      check_frame("t5b", 176);
      check("t5_word", dword(0, 8), 'h0F0);
      check("t5_parity", dbit(19, 8), 0);
      repeat (3) tick();

      // 6: CLOCKS_PER_BIT=4 instance
      exp_words = {10'h3FF}; build_exp(4);
      start_word(1, 10'h3FF);
      capture(1, 0);
      check_frame("t6", 88);
      check("t6_viol_hi", int'(cap[25]), 1);
      check("t6_viol_lo", int'(cap[26]), 0);
      check("t6_bit_lo", int'(cap[1]), 0);
      check("t6_bit_hi", int'(cap[2]), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/coax_tx.md
Name: coax_tx

Overview:
- Transmitter for the 3270 coax link; the transmit-side counterpart of coax_rx.
- Accepts 10-bit words from the shared data bus through a one-word holding register.
- Frames each message: line quiesce, code violation, then per word a sync bit, 10 data bits and a parity bit, then an end sequence.
- Emits a biphase (Manchester) serial stream on tx, with an active flag that enables the external line driver.

Parameters:
- CLOCKS_PER_BIT, 8: clk cycles per bit time. Must be even and >= 4. Half-bit = CLOCKS_PER_BIT/2.

Ports:
- clk  input  1  system clock (19 MHz in the interface2 build)
- reset  input  1  synchronous, active-high reset
- data  input  10  word to transmit, sampled when strobe && ready
- strobe  input  1  load request, one cycle wide
- ready  output  1  holding register empty; a word can be loaded
- active  output  1  high from first quiesce bit through last end-sequence clock
- tx  output  1  serial line output

Behaviour:
- Reset (synchronous, active-high):
  - tx=0, active=0, ready=1.
  - FSM to IDLE; holding register empty; bit and clock counters cleared.
  - Reset mid-message aborts immediately; the next cycle shows the reset values.
- Bit encoding:
  - Each bit lasts CLOCKS_PER_BIT cycles.
  - '1' = low for the first half-bit, high for the second.
  - '0' = high for the first half-bit, low for the second.
- Load handshake:
  - strobe && ready at edge N: holding register <= data, ready=0 from N+1.
  - strobe while ready=0 is ignored; the holding register is unchanged and the word is dropped.
  - When a word moves from holding to the shift register (first clock of SYNC), ready=1 on the following cycle.
- FSM:
  - IDLE: tx=0, active=0. A load makes the next state QUIESCE, with active=1 and the first quiesce clock on the cycle after the strobe edge.
  - QUIESCE: five '1' bits (5*CLOCKS_PER_BIT clocks).
  - VIOLATION: tx high for 3 half-bits, then low for 3 half-bits (3*CLOCKS_PER_BIT clocks).
  - SYNC: one '1' bit. On its first clock, shift register <= holding register and holding becomes empty.
  - DATA: 10 bits, MSB (bit 9) first.
  - PARITY: one bit equal to XOR of the 10 data bits (even parity over data+parity). Parity is computed on the shift-register copy, not the live bus.
  - At the end of the PARITY bit:
    - holding register full -> SYNC (next word, no gap);
    - holding register empty -> END.
  - END: one '0' bit, then tx high for one full bit time, then IDLE.
  - On the transition to IDLE, active=0 and tx=0 on the same cycle.
  - A strobe during END loads the holding register but does not extend the message. IDLE then sees a full holding register and starts a new message (QUIESCE) on the next cycle.
- Timing:
  - Single-word message length: 5+3+1+10+1+2 = 22 bit times (176 clocks at CLOCKS_PER_BIT=8).
  - Each additional queued word adds 12 bit times.
- Counters: clock counter wraps at CLOCKS_PER_BIT-1; bit counter is sized for max(5,10). No combinational path from strobe or data to tx.

Test Plan:
1. Single word 0x2AA loaded in IDLE:
   - active is high for exactly 176 clocks, starting on the cycle after strobe.
   - Decoded bits: 11111, violation, 1, 1010101010, parity 1, 0, high.
   - ready=0 for 1+64 clocks, then 1.
2. Three words 0x001, 0x3FF, 0x000, each strobed on the cycle ready rises:
   - one frame with no END between words; active high for 368 clocks.
   - Parity bits 1, 0, 0.
3. Second strobe (0x155) while ready=0:
   - ignored; only the first word is transmitted and active lasts 176 clocks.
4. Reset asserted during the 5th DATA bit of word 0x2AA:
   - next cycle tx=0, active=0, ready=1.
   - A new strobe then produces a clean 176-clock frame.
5. Strobe 0x0F0 during the END high period:
   - first message ends (active low for one cycle in IDLE).
   - A full new 176-clock frame follows, carrying 0x0F0 with parity 0.
6. CLOCKS_PER_BIT=4 instance, word 0x3FF:
   - active high for 88 clocks.
   - Each bit is 2 clocks low plus 2 clocks high (for '1'); violation is 6 high then 6 low.
